seg_ripple_adder: RTL and testbench



---
 rtl/seg_ripple_adder.sv | 149 ++++++++++++++
 tb/tb_seg_ripple_adder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_ripple_adder.sv
// Multi-cycle segmented ripple-carry adder/subtractor with valid/ready handshake.
// Define SEG_ADD_BIAS_EN to compile in the bias-removal pass ({carry_out, sum} - BIAS).
module seg_ripple_adder #(
    parameter int          WIDTH = 8,
    parameter int          SEG   = 2,
    parameter int unsigned BIAS  = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             underflow,
    output logic [1:0]       state_dbg
);

    localparam int NSEG  = WIDTH / SEG;
    localparam int CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NSEG - 1);

    if (WIDTH < 2 || SEG < 1 || (WIDTH % SEG) != 0 ||
        (WIDTH < 32 && (BIAS >> WIDTH) != 0)) begin : g_bad_params
        $error("seg_ripple_adder: illegal WIDTH/SEG/BIAS combination");
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE; out_valid is high only in DONE and the
    // result is held unchanged until out_ready is seen.
`ifdef SEG_ADD_BIAS_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADD = 2'd1, S_BIAS = 2'd2, S_DONE = 2'd3} state_t;
    localparam logic [WIDTH-1:0] BIAS_L = WIDTH'(BIAS);
    localparam logic [WIDTH-1:0] NBIAS  = ~BIAS_L;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADD = 2'd1, S_DONE = 2'd3} state_t;
`endif

    state_t           state, state_nx;
    logic [CNT_W-1:0] seg_cnt;
    logic             carry_r;
    logic [WIDTH-1:0] op_a, op_b, sum_r;
    logic             carry_out_r;
    int               seg_lo;
    logic [SEG-1:0]   seg_x, seg_y;
    logic [SEG:0]     seg_res;

    always_comb begin
        state_nx = state;
        seg_lo   = int'(seg_cnt) * SEG;
        seg_x    = op_a[seg_lo +: SEG];
        seg_y    = op_b[seg_lo +: SEG];
`ifdef SEG_ADD_BIAS_EN
        // The bias pass reuses the segment adder on the partial result and ~BIAS.
        if (state == S_BIAS) begin
            seg_x = sum_r[seg_lo +: SEG];
            seg_y = NBIAS[seg_lo +: SEG];
        end
`endif
        seg_res = {1'b0, seg_x} + {1'b0, seg_y} + (SEG+1)'(carry_r);
        case (state)
            S_IDLE: if (in_valid) state_nx = S_ADD;
`ifdef SEG_ADD_BIAS_EN
            S_ADD:  if (seg_cnt == LAST_SEG) state_nx = S_BIAS;
            S_BIAS: if (seg_cnt == LAST_SEG) state_nx = S_DONE;
`else
            S_ADD:  if (seg_cnt == LAST_SEG) state_nx = S_DONE;
`endif
            S_DONE: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef SEG_ADD_BIAS_EN
    logic underflow_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            seg_cnt     <= '0;
            carry_r     <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
`ifdef SEG_ADD_BIAS_EN
            underflow_r <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_a    <= a;
                        op_b    <= b ^ {WIDTH{sub}};
                        carry_r <= sub;
                        seg_cnt <= '0;
                    end
                end
                S_ADD: begin
                    sum_r[seg_lo +: SEG] <= seg_res[SEG-1:0];
                    carry_r              <= seg_res[SEG];
                    if (seg_cnt == LAST_SEG) begin
                        seg_cnt     <= '0;
                        carry_out_r <= seg_res[SEG];
`ifdef SEG_ADD_BIAS_EN
                        carry_r     <= 1'b1;
`endif
                    end else begin
                        seg_cnt <= seg_cnt + CNT_W'(1);
                    end
                end
`ifdef SEG_ADD_BIAS_EN
                S_BIAS: begin
                    sum_r[seg_lo +: SEG] <= seg_res[SEG-1:0];
                    carry_r              <= seg_res[SEG];
                    if (seg_cnt == LAST_SEG) begin
                        // Top bit of ~BIAS is 1: bit WIDTH = co ^ 1 ^ c, borrow iff no carry out of it.
                        seg_cnt     <= '0;
                        carry_r     <= 1'b0;
                        carry_out_r <= carry_out_r ^ ~seg_res[SEG];
                        underflow_r <= ~(carry_out_r | seg_res[SEG]);
                    end else begin
                        seg_cnt <= seg_cnt + CNT_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign sum       = sum_r;
    assign carry_out = carry_out_r;
    assign state_dbg = state;
`ifdef SEG_ADD_BIAS_EN
    assign underflow = underflow_r;
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_seg_ripple_adder.sv
// Bench for seg_ripple_adder: directed vectors, random traffic, backpressure and mid-op reset.
// Honours SEG_ADD_BIAS_EN in its reference model when the macro is defined.
module tb_seg_ripple_adder;

    localparam int          W    = 8;
    localparam int          SEG  = 2;
    localparam int unsigned BIAS = 127;
    localparam int          NSEG = W / SEG;
`ifdef SEG_ADD_BIAS_EN
    localparam int LAT = 2 * NSEG;
`else
    localparam int LAT = NSEG;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         underflow;
    logic [1:0]   state_dbg;

    int total = 0;
    int bad   = 0;
    logic [W+1:0] exp_q[$];

    seg_ripple_adder #(.WIDTH(W), .SEG(SEG), .BIAS(BIAS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .underflow(underflow), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Expected {underflow, carry_out, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic ms);
        int unsigned x, d;
        logic        uf;
        if (ms) x = int'(ma) + (1 << W) - int'(mb);
        else    x = int'(ma) + int'(mb);
        uf = 1'b0;
`ifdef SEG_ADD_BIAS_EN
        uf = (x < BIAS);
        d  = (x + (1 << (W + 1)) - BIAS) % (1 << (W + 1));
`else
        d  = x;
`endif
        return {uf, (d >= (1 << W)), W'(d % (1 << W))};
    endfunction

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
        a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL accept_ready: in_ready=%b want 1", in_ready);
        end
        exp_q.push_back(model(ta, tb_v, ts));
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_result(input string name);
        int lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            @(posedge clk); lat++; @(negedge clk);
        end
        total++;
        if (lat != LAT) begin
            bad++; $display("FAIL %s latency: got=%0d want=%0d", name, lat, LAT);
        end
    endtask

    task automatic check_out(input string name, input logic [W+1:0] e);
        total++;
        if ({underflow, carry_out, sum} !== e || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s result: got uf=%b co=%b sum=%h ov=%b want uf=%b co=%b sum=%h ov=1",
                     name, underflow, carry_out, sum, out_valid, e[W+1], e[W], e[W-1:0]);
        end
    endtask

    task automatic take(input string name);
        logic [W+1:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_out(name, e);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL %s release: ov=%b ir=%b want ov=0 ir=1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 ||
            carry_out !== 1'b0 || underflow !== 1'b0) begin
            bad++;
            $display("FAIL reset: ir=%b ov=%b sum=%h co=%b uf=%b want 1 0 00 0 0",
                     in_ready, out_valid, sum, carry_out, underflow);
        end
    endtask

    task automatic test_directed();
        logic [W+1:0] want;
`ifdef SEG_ADD_BIAS_EN
        send(8'h85, 8'h82, 1'b0); wait_result("bias_85_82");
        want = {1'b0, 1'b0, 8'h88}; check_out("bias_85_82_const", want); take("bias_85_82");
        send(8'h20, 8'h10, 1'b0); wait_result("bias_20_10");
        want = {1'b1, 1'b1, 8'hB1}; check_out("bias_20_10_const", want); take("bias_20_10");
`else
        send(8'h5A, 8'h3C, 1'b0); wait_result("add_5a_3c");
        want = {1'b0, 1'b0, 8'h96}; check_out("add_5a_3c_const", want); take("add_5a_3c");
        send(8'hFF, 8'h01, 1'b0); wait_result("add_ff_01");
        want = {1'b0, 1'b1, 8'h00}; check_out("add_ff_01_const", want); take("add_ff_01");
        send(8'h10, 8'h20, 1'b1); wait_result("sub_10_20");
        want = {1'b0, 1'b0, 8'hF0}; check_out("sub_10_20_const", want); take("sub_10_20");
`endif
        send(8'h40, 8'h40, 1'b1); wait_result("sub_equal"); take("sub_equal");
        send(8'h00, 8'h01, 1'b1); wait_result("sub_borrow"); take("sub_borrow");
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom));
            wait_result("random");
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                @(posedge clk); @(negedge clk);
                total++;
                if (in_ready !== 1'b0) begin
                    bad++; $display("FAIL random_hold_ready: ir=%b want 0", in_ready);
                end
            end
            take("random");
        end
    endtask

    task automatic test_backpressure();
        logic [W+1:0] e;
        logic [W-1:0] na, nb;
        logic         ns;
        send(8'hC3, 8'h5D, 1'b0);
        wait_result("bp_first");
        na = W'($urandom); nb = W'($urandom); ns = 1'($urandom);
        a = na; b = nb; sub = ns; in_valid = 1'b1;
        e = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {underflow, carry_out, sum} !== e) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: ir=%b ov=%b res=%h want ir=0 ov=1 res=%h",
                         i, in_ready, out_valid, {underflow, carry_out, sum}, e);
            end
        end
        check_out("bp_first", exp_q.pop_front());
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        send(na, nb, ns);
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_accept: ir=%b want 0 after accept", in_ready);
        end
        wait_result("bp_second");
        take("bp_second");
    endtask

    task automatic test_reset_mid();
        send(8'hFF, 8'hFF, 1'b0);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0) begin
            bad++;
            $display("FAIL reset_mid: ov=%b ir=%b sum=%h want 0 1 00", out_valid, in_ready, sum);
        end
        send(8'h01, 8'h01, 1'b0);
        wait_result("after_reset");
`ifndef SEG_ADD_BIAS_EN
        total++;
        if (sum !== 8'h02 || carry_out !== 1'b0) begin
            bad++; $display("FAIL after_reset_const: sum=%h co=%b want 02 0", sum, carry_out);
        end
`endif
        take("after_reset");
    endtask

    task automatic test_back_to_back();
        int gap;
        send(8'h11, 8'h22, 1'b0);
        wait_result("b2b_first");
        take("b2b_first");
        gap = 0;
        send(8'h80, 8'h80, 1'b0);
        while (out_valid !== 1'b1 && gap < 200) begin @(posedge clk); gap++; @(negedge clk); end
        total++;
        if (gap != LAT) begin
            bad++; $display("FAIL b2b_latency: got=%0d want=%0d", gap, LAT);
        end
        take("b2b_second");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
